reaction_game_ctrl: RTL and testbench

// Sequencer for the reaction-timer game. It arms a pseudo-random delay, lights the LED,
// and measures button latency in prescaled ticks. It detects false starts and timeouts,

---
 rtl/reaction_game_ctrl.sv | 141 ++++++++++++++
 tb/tb_reaction_game_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: reaction-timer sequencer (random delay, LED, latency count, SPI handoff)
module reaction_game_ctrl #(
    parameter int          TICK_DIV  = 1000,
    parameter int          MIN_DELAY = 64,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       button,
    output logic       led,
    output logic       busy,
    output logic [7:0] time_out,
    output logic       fault,
    output logic       timeout_flag,
    output logic [7:0] best_time,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_LIGHT, S_REPORT} state_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [8:0]    delay_q, delay_d;
    logic [7:0]    rt_q, rt_d;
    logic [15:0]   lfsr_q;
    logic          btn_meta_q, btn_sync_q, btn_prev_q;
    logic [7:0]    time_q, time_d, best_q, best_d, txd_q, txd_d;
    logic          fault_q, fault_d, to_q, to_d, txv_q, txv_d;
    logic          press, tick, rep;
    logic [7:0]    res;

    assign press = btn_sync_q & ~btn_prev_q;
    assign tick  = presc_q == TICK_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            delay_q    <= '0;
            rt_q       <= '0;
            lfsr_q     <= LFSR_SEED;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            time_q     <= '0;
            fault_q    <= 1'b0;
            to_q       <= 1'b0;
            best_q     <= 8'hFF;
            txd_q      <= '0;
            txv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            delay_q    <= delay_d;
            rt_q       <= rt_d;
            lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            btn_meta_q <= button;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
            time_q     <= time_d;
            fault_q    <= fault_d;
            to_q       <= to_d;
            best_q     <= best_d;
            txd_q      <= txd_d;
            txv_q      <= txv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        delay_d = delay_q;
        rt_d    = rt_q;
        time_d  = time_q;
        fault_d = fault_q;
        to_d    = to_q;
        best_d  = best_q;
        txd_d   = txd_q;
        txv_d   = txv_q;
        rep     = 1'b0;
        res     = rt_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_WAIT;
                presc_d = '0;
                delay_d = 9'(MIN_DELAY) + {1'b0, lfsr_q[7:0]};
                fault_d = 1'b0;
                to_d    = 1'b0;
            end
            // a press on the final delay tick still counts as a false start
            S_WAIT: if (press) begin
                rep     = 1'b1;
                res     = 8'hFF;
                fault_d = 1'b1;
            end else if (tick) begin
                delay_d = delay_q - 1'b1;
                if (delay_q == 9'd1) begin
                    state_d = S_LIGHT;
                    rt_d    = '0;
                end
            end
            S_LIGHT: if (press) begin
                rep    = 1'b1;
                best_d = rt_q < best_q ? rt_q : best_q;
            end else if (tick) begin
                if (rt_q == 8'hFE) begin
                    rep  = 1'b1;
                    res  = 8'hFE;
                    to_d = 1'b1;
                end else
                    rt_d = rt_q + 1'b1;
            end
            S_REPORT: if (txv_q && tx_ready) begin
                txv_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rep) begin
            state_d = S_REPORT;
            time_d  = res;
            txd_d   = res;
            txv_d   = 1'b1;
        end
    end

    always_comb begin
        led          = state_q == S_LIGHT;
        busy         = state_q != S_IDLE;
        time_out     = time_q;
        fault        = fault_q;
        timeout_flag = to_q;
        best_time    = best_q;
        tx_data      = txd_q;
        tx_valid     = txv_q;
    end
endmodule

// File: tb/tb_reaction_game_ctrl.sv
// tb_reaction_game_ctrl: directed + randomized rounds checked against a cycle-timeline model
module tb_reaction_game_ctrl;
    localparam int          TD   = 4;
    localparam int          MD   = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0, rst, start, button, tx_ready;
    logic       led, busy, fault, timeout_flag, tx_valid;
    logic [7:0] time_out, best_time, tx_data;
    int         tests = 0, fails = 0, cyc = 0, rst_edge = 0;
    logic [7:0] best = 8'hFF;

    reaction_game_ctrl #(.TICK_DIV(TD), .MIN_DELAY(MD), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .button(button), .led(led), .busy(busy),
        .time_out(time_out), .fault(fault), .timeout_flag(timeout_flag), .best_time(best_time),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // value of the random source after n free-running shifts from the seed
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] l = SEED;
        for (int i = 0; i < n; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        return l;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        rst_edge = cyc;
        best = 8'hFF;
    endtask

    // mode 0: press giving result r, 1: false start, 2: timeout; abort_at>0 resets in LIGHT
    task automatic round(input int mode, input int r, input int rdy_wait, input int abort_at);
        int e0, d, l, p;
        logic [15:0] lf;
        logic [7:0]  exp;
        start = 1'b1;
        step();
        e0 = cyc;
        start = 1'b0;
        lf = lfsr_after(e0 - 1 - rst_edge);
        d = MD + int'(lf[7:0]);
        l = e0 + TD * d;
        chk("busy_wait", busy, 1);
        chk("fault_clr", fault, 0);
        chk("to_clr", timeout_flag, 0);
        p = mode == 1 ? int'($urandom_range(l, e0 + 3)) :
            mode == 0 ? l + TD * r + 1 + int'($urandom_range(TD - 1, 0)) : l + TD * 255;
        if (abort_at > 0) p = l + abort_at;
        while (cyc < p) begin
            chk("led", led, cyc >= l);
            if (abort_at == 0 && mode != 2 && cyc == p - 3) button = 1'b1;
            step();
        end
        if (abort_at > 0) begin
            chk("led_pre_abort", led, 1);
            rst = 1'b1;
            step();
            chk("abort_led", led, 0);
            chk("abort_txv", tx_valid, 0);
            chk("abort_best", best_time, 8'hFF);
            chk("abort_busy", busy, 0);
            step();
            rst = 1'b0;
            rst_edge = cyc;
            best = 8'hFF;
            return;
        end
        exp = mode == 1 ? 8'hFF : mode == 2 ? 8'hFE : 8'(r);
        if (mode == 0 && exp < best) best = exp;
        chk("rep_txv", tx_valid, 1);
        chk("rep_time", time_out, exp);
        chk("rep_txd", tx_data, exp);
        chk("rep_led", led, 0);
        chk("rep_fault", fault, mode == 1);
        chk("rep_to", timeout_flag, mode == 2);
        chk("rep_best", best_time, best);
        button = 1'b0;
        start = rdy_wait > 0;
        for (int i = 0; i < rdy_wait; i++) begin
            step();
            chk("bp_txv", tx_valid, 1);
            chk("bp_txd", tx_data, exp);
            chk("bp_busy", busy, 1);
        end
        start = 1'b0;
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("acc_txv", tx_valid, 0);
        chk("acc_busy", busy, 0);
        chk("acc_time", time_out, exp);
        step();
        chk("idle_txv", tx_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        button = 1'b0;
        tx_ready = 1'b0;
        do_reset();
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_time", time_out, 0);
        chk("rst_fault", fault, 0);
        chk("rst_to", timeout_flag, 0);
        chk("rst_best", best_time, 8'hFF);
        chk("rst_txd", tx_data, 0);
        chk("rst_txv", tx_valid, 0);
        round(0, 5, 0, 0);
        round(1, 0, 0, 0);
        round(0, int'($urandom_range(20, 1)), 0, 0);
        round(2, 0, 0, 0);
        round(0, int'($urandom_range(30, 0)), 10, 0);
        do_reset();
        round(0, 9, 0, 0);
        round(0, 3, 1, 0);
        round(0, 7, 0, 0);
        for (int k = 0; k < 4; k++)
            round(int'($urandom_range(1, 0)), int'($urandom_range(40, 0)), int'($urandom_range(3, 0)), 0);
        round(0, 0, 0, 9);
        round(0, int'($urandom_range(15, 0)), 2, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
